// File: rtl/pmod_qenc_core.sv
// pmod_qenc_core
// Multi-channel quadrature rotary-encoder core for the slot bus.
// Each channel synchronises and debounces its A, B, button and switch pins.
// It decodes quadrature in x4 or x1 mode into a signed position counter, and
// it latches sticky button-press and illegal-transition flags.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   cs       slot select, qualifies write
//   read     read strobe (reads have no side effects)
//   write    write strobe
//   addr     word address: 0 STATUS, 1 CTRL, 2 DB_LIMIT, 3+i POS_i
//   wr_data  write data
//   rd_data  read data, combinational mux of addr
//   enc_a    raw quadrature A, one bit per channel
//   enc_b    raw quadrature B, one bit per channel
//   enc_btn  raw push-button, one bit per channel
//   enc_sw   raw slide switch, one bit per channel
module pmod_qenc_core #(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 16,
    parameter int DB_W       = 16,
    parameter int DB_DEFAULT = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    input  logic [N_CH-1:0] enc_a,
    input  logic [N_CH-1:0] enc_b,
    input  logic [N_CH-1:0] enc_btn,
    input  logic [N_CH-1:0] enc_sw
);

    localparam int NSIG = 4 * N_CH;
    localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [NSIG-1:0]  raw, sync1, sync2, filt;
    logic [DB_W-1:0]  db_cnt [NSIG];
    logic [DB_W-1:0]  db_limit, eff_limit;
    logic [1:0]       ctrl;
    logic [CNT_W-1:0] pos [N_CH];
    logic [1:0]       prev_ab [N_CH];
    logic [N_CH-1:0]  prev_btn, btn_evt, err;
    logic [N_CH-1:0]  filt_a, filt_b, filt_btn, filt_sw;
    logic [N_CH-1:0]  step_up, step_dn, err_set, btn_rise;
    logic [N_CH-1:0]  clr_evt, clr_err;
    logic             wr_en;
    logic             unused_bits;

    // All pins of all channels share one synchroniser/filter vector.
    // The layout is A, then B, then BTN, then SW, each N_CH wide.
    assign raw      = {enc_sw, enc_btn, enc_b, enc_a};
    assign filt_a   = filt[N_CH-1:0];
    assign filt_b   = filt[2*N_CH-1:N_CH];
    assign filt_btn = filt[3*N_CH-1:2*N_CH];
    assign filt_sw  = filt[4*N_CH-1:3*N_CH];

    assign wr_en     = cs & write;
    assign eff_limit = (db_limit == '0) ? DB_W'(1) : db_limit;
    assign btn_rise  = filt_btn & ~prev_btn;
    assign clr_evt   = (wr_en && addr == 5'd0) ? wr_data[16 +: N_CH] : '0;
    assign clr_err   = (wr_en && addr == 5'd0) ? wr_data[24 +: N_CH] : '0;

    // Reads carry no side effects, so the read strobe is intentionally ignored.
    assign unused_bits = ^{read, wr_data};

    // Quadrature step decode per channel, comparing last cycle's filtered {A,B}
    // with the current one. In x1 mode, only the transitions into 00 count.
    for (genvar g = 0; g < N_CH; g++) begin : g_dec
        logic [1:0] cur;
        logic [1:0] pv;
        logic       fwd4, rev4;
        assign cur  = {filt_a[g], filt_b[g]};
        assign pv   = prev_ab[g];
        assign fwd4 = (pv == 2'b00 && cur == 2'b01) || (pv == 2'b01 && cur == 2'b11) ||
                      (pv == 2'b11 && cur == 2'b10) || (pv == 2'b10 && cur == 2'b00);
        assign rev4 = (pv == 2'b00 && cur == 2'b10) || (pv == 2'b10 && cur == 2'b11) ||
                      (pv == 2'b11 && cur == 2'b01) || (pv == 2'b01 && cur == 2'b00);
        assign step_up[g] = ctrl[0] ? (pv == 2'b10 && cur == 2'b00) : fwd4;
        assign step_dn[g] = ctrl[0] ? (pv == 2'b01 && cur == 2'b00) : rev4;
        assign err_set[g] = ((cur ^ pv) == 2'b11);
    end

    // Two-flop synchroniser followed by a per-signal debounce filter.
    // The ">=" comparison lets a counter that already passed a newly lowered
    // limit commit on the next cycle that the synced value still differs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int k = 0; k < NSIG; k++) db_cnt[k] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int k = 0; k < NSIG; k++) begin
                if (sync2[k] == filt[k]) begin
                    db_cnt[k] <= '0;
                end else if (({1'b0, db_cnt[k]} + {{DB_W{1'b0}}, 1'b1}) >= {1'b0, eff_limit}) begin
                    filt[k]   <= sync2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    // Control registers written from the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= '0;
            db_limit <= DB_W'(DB_DEFAULT);
        end else begin
            if (wr_en && addr == 5'd1) ctrl     <= wr_data[1:0];
            if (wr_en && addr == 5'd2) db_limit <= wr_data[DB_W-1:0];
        end
    end

    // Position counters, edge history and sticky flags.
    // A CPU write to a position drops any step that occurs in the same cycle.
    // For the flags, a new event wins over a write-1-to-clear on the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_btn <= '0;
            btn_evt  <= '0;
            err      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pos[i]     <= '0;
                prev_ab[i] <= '0;
            end
        end else begin
            prev_btn <= filt_btn;
            btn_evt  <= (btn_evt & ~clr_evt) | btn_rise;
            err      <= (err & ~clr_err) | err_set;
            for (int i = 0; i < N_CH; i++) begin
                prev_ab[i] <= {filt_a[i], filt_b[i]};
                if (wr_en && addr == 5'(3 + i)) begin
                    pos[i] <= wr_data[CNT_W-1:0];
                end else if (step_up[i]) begin
                    if (!(ctrl[1] && pos[i] == POS_MAX)) pos[i] <= pos[i] + CNT_W'(1);
                end else if (step_dn[i]) begin
                    if (!(ctrl[1] && pos[i] == POS_MIN)) pos[i] <= pos[i] - CNT_W'(1);
                end
            end
        end
    end

    // Read mux. Unmapped addresses and absent channels read as zero.
    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: begin
                rd_data[0  +: N_CH] = filt_btn;
                rd_data[8  +: N_CH] = filt_sw;
                rd_data[16 +: N_CH] = btn_evt;
                rd_data[24 +: N_CH] = err;
            end
            5'd1: rd_data[1:0] = ctrl;
            5'd2: rd_data[DB_W-1:0] = db_limit;
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (addr == 5'(3 + i)) rd_data = 32'(signed'(pos[i]));
                end
            end
        endcase
    end

endmodule
